// File: rtl/modulo_time_counter_pkg.sv
// Shared constants and encodings for the clock/alarm field counters.
// Default moduli cover the hours, minutes and seconds fields.
package time_counter_pkg;

    localparam int HOURS_MODULUS         = 24;
    localparam int MINUTES_MODULUS       = 60;
    localparam int SECONDS_MODULUS       = 60;
    localparam int DEFAULT_HOLD_CYCLES   = 500;
    localparam int DEFAULT_REPEAT_CYCLES = 100;

    typedef enum logic {
        MODE_RUN = 1'b0,
        MODE_SET = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/modulo_time_counter_if.sv
// Control and status bundle of one field counter.
// The master drives the controls and reads back the count and pulses; the slave is the counter itself.
interface modulo_time_counter_if #(
    parameter int WIDTH = 7
);
    logic             clear;
    logic             mode;
    logic             manual_increment;
    logic             manual_decrement;
    logic             count;
    logic             count_down;
    logic [WIDTH-1:0] alarm_value;
    logic [WIDTH-1:0] out;
    logic             ripple_carry_out;
    logic             ripple_borrow_out;
    logic             match;

    modport master (
        output clear, mode, manual_increment, manual_decrement, count, count_down, alarm_value,
        input  out, ripple_carry_out, ripple_borrow_out, match
    );

    modport slave (
        input  clear, mode, manual_increment, manual_decrement, count, count_down, alarm_value,
        output out, ripple_carry_out, ripple_borrow_out, match
    );
endinterface

// File: rtl/modulo_time_counter_button_repeat.sv
// Button edge detector with hold-to-repeat timer.
// step is combinational so the parent's registered count moves one cycle after the qualifying edge.
module button_repeat #(
    parameter int HOLD_CYCLES   = 500,
    parameter int REPEAT_CYCLES = 100
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic cancel,
    input  logic btn,
    output logic step
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic          hist_q, hist_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          rise;
    logic          repeat_tick;

    // hold_q saturates at HOLD_CYCLES; from then on rep_q paces the repeats, firing on each return to zero
    always_comb begin
        hist_d      = btn;
        hold_d      = hold_q;
        rep_d       = rep_q;
        rise        = btn & ~hist_q;
        repeat_tick = btn & (hold_q == HOLD_MAX) & (rep_q == '0);
        if (clear || cancel || !btn) begin
            hold_d = '0;
            rep_d  = '0;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HW'(1);
        end else begin
            rep_d = (rep_q == REP_LAST) ? '0 : rep_q + RW'(1);
        end
        step = (rise | repeat_tick) & ~cancel;
    end

    // History resets high so a button held through reset produces no step
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hist_q <= 1'b1;
            hold_q <= '0;
            rep_q  <= '0;
        end else begin
            hist_q <= hist_d;
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end
endmodule

// File: rtl/modulo_time_counter.sv
// Modulo up/down counter for one time field, cascadable via registered carry/borrow pulses.
// Set mode steps from button edges or auto-repeat; run mode steps on count and raises carry/borrow/match.
module modulo_time_counter
    import time_counter_pkg::*;
#(
    parameter int MODULUS       = HOURS_MODULUS,
    parameter int WIDTH         = 7,
    parameter int INIT          = 0,
    parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES
) (
    input logic                   clk,
    input logic                   reset_n,
    modulo_time_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);

    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             match_q, match_d;
    logic [WIDTH-1:0] inc_val, dec_val;
    logic             inc_step, dec_step, cancel;

    assign cancel = bus.manual_increment & bus.manual_decrement;

    button_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_inc (
        .clk(clk), .reset_n(reset_n), .clear(bus.clear), .cancel(cancel),
        .btn(bus.manual_increment), .step(inc_step)
    );

    button_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_dec (
        .clk(clk), .reset_n(reset_n), .clear(bus.clear), .cancel(cancel),
        .btn(bus.manual_decrement), .step(dec_step)
    );

    // Set-mode steps never pulse, so adjusting a field leaves the next stage untouched
    always_comb begin
        out_d    = out_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        match_d  = 1'b0;
        inc_val  = (out_q == MAX_VAL) ? '0 : out_q + WIDTH'(1);
        dec_val  = (out_q == '0) ? MAX_VAL : out_q - WIDTH'(1);
        if (bus.clear) begin
            out_d = INIT_VAL;
        end else if (mode_e'(bus.mode) == MODE_SET) begin
            if (inc_step)      out_d = inc_val;
            else if (dec_step) out_d = dec_val;
        end else if (bus.count) begin
            if (dir_e'(bus.count_down) == DIR_DOWN) begin
                out_d    = dec_val;
                borrow_d = (out_q == '0);
            end else begin
                out_d   = inc_val;
                carry_d = (out_q == MAX_VAL);
            end
            match_d = (out_d == bus.alarm_value);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_q    <= INIT_VAL;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            out_q    <= out_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            match_q  <= match_d;
        end
    end

    assign bus.out               = out_q;
    assign bus.ripple_carry_out  = carry_q;
    assign bus.ripple_borrow_out = borrow_q;
    assign bus.match             = match_q;
endmodule

// File: tb/tb_modulo_time_counter.sv
// Directed bench: one hours-field counter (INIT=5, short repeat timing) plus a seconds/minutes/hours cascade.
// Inputs change and outputs are sampled just after the falling edge.
module tb_modulo_time_counter;
    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    modulo_time_counter_if #(.WIDTH(7)) m ();
    modulo_time_counter_if #(.WIDTH(6)) sec_if ();
    modulo_time_counter_if #(.WIDTH(6)) min_if ();
    modulo_time_counter_if #(.WIDTH(5)) hr_if ();

    modulo_time_counter #(.MODULUS(24), .WIDTH(7), .INIT(5), .HOLD_CYCLES(4), .REPEAT_CYCLES(2))
        dut (.clk(clk), .reset_n(reset_n), .bus(m));
    modulo_time_counter #(.MODULUS(60), .WIDTH(6), .INIT(0))
        u_sec (.clk(clk), .reset_n(reset_n), .bus(sec_if));
    modulo_time_counter #(.MODULUS(60), .WIDTH(6), .INIT(0))
        u_min (.clk(clk), .reset_n(reset_n), .bus(min_if));
    modulo_time_counter #(.MODULUS(24), .WIDTH(5), .INIT(0))
        u_hr (.clk(clk), .reset_n(reset_n), .bus(hr_if));

    assign min_if.count = sec_if.ripple_carry_out;
    assign hr_if.count  = min_if.ripple_carry_out;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_main(input string tag, input int exp_out, input logic exp_c, input logic exp_b, input logic exp_m);
        check_output({tag, ".out"}, 32'(m.out), 32'(exp_out));
        check_output({tag, ".carry"}, 32'(m.ripple_carry_out), 32'(exp_c));
        check_output({tag, ".borrow"}, 32'(m.ripple_borrow_out), 32'(exp_b));
        check_output({tag, ".match"}, 32'(m.match), 32'(exp_m));
    endtask

    task automatic apply_stimulus(input logic mode, input logic inc, input logic dec,
                                  input logic cnt, input logic down, input int cycles);
        m.mode = mode; m.manual_increment = inc; m.manual_decrement = dec;
        m.count = cnt; m.count_down = down;
        tick(cycles);
    endtask

    initial begin
        int hold_exp [10] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4};
        reset_n = 1'b0;
        m.clear = 1'b0; m.alarm_value = 7'd20;
        m.mode = 1'b0; m.manual_increment = 1'b0; m.manual_decrement = 1'b0;
        m.count = 1'b0; m.count_down = 1'b0;
        sec_if.clear = 1'b0; sec_if.mode = 1'b0; sec_if.manual_increment = 1'b0;
        sec_if.manual_decrement = 1'b0; sec_if.count = 1'b0; sec_if.count_down = 1'b0;
        sec_if.alarm_value = 6'd30;
        min_if.clear = 1'b0; min_if.mode = 1'b0; min_if.manual_increment = 1'b0;
        min_if.manual_decrement = 1'b0; min_if.count_down = 1'b0; min_if.alarm_value = 6'd30;
        hr_if.clear = 1'b0; hr_if.mode = 1'b0; hr_if.manual_increment = 1'b0;
        hr_if.manual_decrement = 1'b0; hr_if.count_down = 1'b0; hr_if.alarm_value = 5'd12;
        tick(2);
        check_main("reset", 5, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;

        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4);
        check_main("count_to_9", 9, 1'b0, 1'b0, 1'b0);
        m.count = 1'b0; m.clear = 1'b1;
        tick(1);
        check_main("clear", 5, 1'b0, 1'b0, 1'b0);
        m.clear = 1'b0;

        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5);
        check_main("down_to_0", 0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        check_main("borrow_wrap", 23, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        check_main("borrow_one_cycle", 23, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        check_main("carry_wrap", 0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        check_main("carry_one_cycle", 0, 1'b0, 1'b0, 1'b0);

        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        check_main("set_dec_wrap", 23, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        check_main("set_dec_release", 23, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6);
        check_main("set_both_cancel", 23, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        check_main("set_inc_wrap", 0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);

        m.manual_increment = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check_output($sformatf("hold_cycle%0d", i + 1), 32'(m.out), 32'(hold_exp[i]));
        end
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        check_main("hold_release", 4, 1'b0, 1'b0, 1'b0);

        m.alarm_value = 7'd7;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        check_main("pre_match", 6, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        check_main("run_match", 7, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        check_main("match_one_cycle", 7, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        check_main("set_no_match", 7, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);

        sec_if.mode = 1'b1; min_if.mode = 1'b1; hr_if.mode = 1'b1;
        sec_if.manual_decrement = 1'b1; min_if.manual_decrement = 1'b1; hr_if.manual_decrement = 1'b1;
        tick(1);
        sec_if.manual_decrement = 1'b0; min_if.manual_decrement = 1'b0; hr_if.manual_decrement = 1'b0;
        sec_if.mode = 1'b0; min_if.mode = 1'b0; hr_if.mode = 1'b0;
        tick(1);
        check_output("casc_pre.sec", 32'(sec_if.out), 32'd59);
        check_output("casc_pre.min", 32'(min_if.out), 32'd59);
        check_output("casc_pre.hr", 32'(hr_if.out), 32'd23);
        check_output("casc_pre.min_carry", 32'(min_if.ripple_carry_out), 32'd0);
        sec_if.count = 1'b1;
        tick(1);
        sec_if.count = 1'b0;
        check_output("casc1.sec", 32'(sec_if.out), 32'd0);
        check_output("casc1.sec_carry", 32'(sec_if.ripple_carry_out), 32'd1);
        check_output("casc1.min", 32'(min_if.out), 32'd59);
        tick(1);
        check_output("casc2.sec_carry", 32'(sec_if.ripple_carry_out), 32'd0);
        check_output("casc2.min", 32'(min_if.out), 32'd0);
        check_output("casc2.min_carry", 32'(min_if.ripple_carry_out), 32'd1);
        check_output("casc2.hr", 32'(hr_if.out), 32'd23);
        tick(1);
        check_output("casc3.min_carry", 32'(min_if.ripple_carry_out), 32'd0);
        check_output("casc3.hr", 32'(hr_if.out), 32'd0);
        check_output("casc3.hr_carry", 32'(hr_if.ripple_carry_out), 32'd1);
        tick(1);
        check_output("casc4.hr_carry", 32'(hr_if.ripple_carry_out), 32'd0);
        check_output("casc4.sec", 32'(sec_if.out), 32'd0);

        reset_n = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        check_main("reset_overrides", 5, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/modulo_time_counter.md
# modulo_time_counter

Parametrised modulo up/down counter for one field (hours, minutes, seconds) of the alarm/clock datapath. Its modulus, width, count direction and button auto-repeat timing are all configurable, so one block can replace the per-field counters. Stages cascade through registered carry/borrow pulses. Set mode adds proper decrement, single-step edge detection and hold-to-repeat. An alarm-compare pulse feeds the alarm sequencer.

## Interface
Parameters:
- MODULUS, 24: number of states; counter range 0..MODULUS-1; must be ≥2.
- WIDTH, 7: counter width; 2^WIDTH ≥ MODULUS.
- INIT, 0: value loaded on reset and on clear; must be < MODULUS.
- HOLD_CYCLES, 500: consecutive held cycles before auto-repeat starts; ≥1.
- REPEAT_CYCLES, 100: cycles between auto-repeat steps; ≥1.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- clear  in  1  synchronous functional clear to INIT, active high.
- mode  in  1  1 = set mode (manual adjust), 0 = run mode.
- manual_increment  in  1  level from debounced button.
- manual_decrement  in  1  level from debounced button.
- count  in  1  run-mode tick (carry/borrow of lower stage or prescaler).
- count_down  in  1  run-mode direction: 0 up, 1 down.
- alarm_value  in  WIDTH  compare value from the alarm register.
- out  out  WIDTH  current counter value.
- ripple_carry_out  out  1  one-cycle pulse on run-mode wrap MODULUS-1→0.
- ripple_borrow_out  out  1  one-cycle pulse on run-mode wrap 0→MODULUS-1.
- match  out  1  one-cycle pulse when a run-mode step lands on alarm_value.

## Operation
- Priority per cycle: reset_n low > clear > mode=1 (set) > count (run).
- Reset: out=INIT; ripple_carry_out, ripple_borrow_out, match=0; repeat timers=0; button history regs=1, so a button held through reset gives no step.
- clear: out=INIT; pulses 0; repeat timers cleared; button history still updated.
- Set mode:
  - Step request = rising edge of a button, or an auto-repeat tick.
  - Auto-repeat: hold counter increments while the button is held. At HOLD_CYCLES it issues a step, then one step every REPEAT_CYCLES while held. Release zeroes it.
  - inc step: out = (out==MODULUS-1) ? 0 : out+1. dec step: out = (out==0) ? MODULUS-1 : out-1.
  - Both buttons high in the same cycle: no step, both hold counters zeroed.
  - Set-mode wraps generate no carry, borrow or match pulses. The next stage is never disturbed.
- Run mode (mode=0):
  - count=1, count_down=0: step up. ripple_carry_out=1 in the cycle out becomes 0.
  - count=1, count_down=1: step down. ripple_borrow_out=1 in the cycle out becomes MODULUS-1.
  - match=1 in the cycle out becomes equal to alarm_value, only after a run-mode step.
  - count=0: out holds, pulses 0.
  - Button history and hold counters keep tracking in run mode, but no steps are issued.
- All pulses are default-0 every cycle. Width arithmetic is done in WIDTH bits; out never leaves 0..MODULUS-1.

## Timing
- All outputs registered. out, carry, borrow and match update together, one cycle after the qualifying input edge.
- Cascade latency: one cycle per stage. Stage N+1 sees stage N's carry in the cycle after stage N wraps.
- Button rising edge at cycle t → out changes at t+1.
- Continuous hold from cycle t:
  - First (edge) step at t+1.
  - Repeat steps at t+HOLD_CYCLES+1, then every REPEAT_CYCLES.
- Mode switch mid-hold: set→run freezes stepping immediately. Run→set with the button still held resumes repeat from the current hold count, with no new edge.
- reset_n low mid-sequence overrides everything in that cycle.

## Structure
- Shared package `time_counter_pkg`: default MODULUS constants (HOURS=24, MINUTES=60, SECONDS=60), default HOLD_CYCLES/REPEAT_CYCLES, and mode/direction encodings.
- One sub-module `button_repeat`: edge detect plus hold/repeat timer, parametrised by HOLD_CYCLES and REPEAT_CYCLES, output one-cycle `step`. Instantiated twice, for increment and decrement. The simultaneous-press cancel lives in the parent.

## Test plan
- Reset/clear: INIT=5, reset_n low 1 cycle → out=5, all pulses 0. Count to 9, pulse clear → out=5 next cycle.
- Run wrap both ways, MODULUS=24: from 23, count=1, count_down=0 → out=0 and ripple_carry_out=1 for exactly one cycle. From 0 with count_down=1 → out=23 and ripple_borrow_out=1.
- Set-mode decrement: out=0, mode=1, one manual_decrement edge → out=23, no borrow. Simultaneous inc+dec → out unchanged.
- Auto-repeat with HOLD_CYCLES=4, REPEAT_CYCLES=2: hold manual_increment 10 cycles from out=0 → steps at cycles 1, 5, 7, 9; out=4; release → no further steps.
- Alarm match with alarm_value=7: run-mode step 6→7 → match pulse one cycle. Set mode to 7 → no match pulse.
- Cascade MODULUS=60 into MODULUS=24: seconds at 59, minutes at 59, hours at 23 → one tick wraps all three to 0 on successive cycles, with one carry pulse per stage.
